// File: rtl/qenc_pkg.sv
// ----------------------------------------------------------------------------
// qenc_pkg
// Shared definitions for the quadrature encoder counter:
//   - Gray-code state values S00/S01/S11/S10 for the {A,B} channel pair
//   - decoding mode selectors MODE_X4 / MODE_X1
//   - step_t classification and qenc_step(), which classifies one
//     {prev, cur} transition as CW, CCW, no event or illegal.
// No ports (package).
// ----------------------------------------------------------------------------
package qenc_pkg;

   localparam logic [1:0] S00 = 2'b00;
   localparam logic [1:0] S01 = 2'b01;
   localparam logic [1:0] S11 = 2'b11;
   localparam logic [1:0] S10 = 2'b10;

   localparam int MODE_X4 = 0;
   localparam int MODE_X1 = 1;

   typedef enum logic [1:0] {
      STEP_NONE = 2'b00,
      STEP_CW   = 2'b01,
      STEP_CCW  = 2'b10,
      STEP_ILL  = 2'b11
   } step_t;

   // Classify one transition. CW order is 00->01->11->10->00.
   function automatic step_t qenc_step(input logic [1:0] prev,
                                       input logic [1:0] cur,
                                       input logic       x1_mode);
      step_t raw;
      case ({prev, cur})
         {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: raw = STEP_CW;
         {S00, S10}, {S10, S11}, {S11, S01}, {S01, S00}: raw = STEP_CCW;
         {S00, S11}, {S11, S00}, {S01, S10}, {S10, S01}: raw = STEP_ILL;
         default:                                        raw = STEP_NONE;
      endcase
      // In x1 mode only the edges that land on the detent (00) count:
      // 10->00 (CW) and 01->00 (CCW). Illegal jumps are still reported.
      if (x1_mode && (cur != S00) && (raw != STEP_ILL)) begin
         return STEP_NONE;
      end else begin
         return raw;
      end
   endfunction

endpackage

// File: rtl/qenc_debounce.sv
// ----------------------------------------------------------------------------
// qenc_debounce
// Two-flop synchroniser followed by a counting debounce filter. The filtered
// value toggles only after the synchronised input has differed from it for
// DEB_CNT consecutive cycles (pin-to-dout latency 2 + DEB_CNT cycles).
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   din  - raw asynchronous input
//   dout - filtered, registered output (0 after reset)
// ----------------------------------------------------------------------------
module qenc_debounce
   import qenc_pkg::*;
#(
   parameter int DEB_CNT  = 80,
   parameter int DEB_BITS = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam logic [DEB_BITS-1:0] CNT_LAST = DEB_BITS'(DEB_CNT - 1);
   localparam logic [DEB_BITS-1:0] CNT_ONE  = DEB_BITS'(1);
   localparam logic [DEB_BITS-1:0] CNT_ZERO = DEB_BITS'(0);

   logic                sync1_r;
   logic                sync2_r;
   logic                stable_r;
   logic [DEB_BITS-1:0] cnt_r;

   // Metastability guard for the asynchronous pin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= din;
         sync2_r <= sync1_r;
      end
   end

   // Stability counter: any return to the held value restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stable_r <= 1'b0;
         cnt_r    <= CNT_ZERO;
      end else if (sync2_r == stable_r) begin
         cnt_r    <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
         stable_r <= ~stable_r;
         cnt_r    <= CNT_ZERO;
      end else begin
         cnt_r    <= cnt_r + CNT_ONE;
      end
   end

   assign dout = stable_r;

endmodule

// File: rtl/quad_encoder_counter.sv
// ----------------------------------------------------------------------------
// quad_encoder_counter
// Synchronises, debounces and quadrature-decodes one A/B encoder pair into
// step pulses and a signed position count.
// Optional feature macro: QENC_INDEX_EN (adds debounced index input idx whose
// rising edge, while ready and enabled, zeroes pos).
// Ports:
//   clk   - 10 MHz system clock
//   rst   - asynchronous active-low reset
//   d1/d2 - raw encoder channels A/B
//   en    - count enable
//   clr   - synchronous clear of pos and err (wins over everything)
//   idx   - raw index input (only with QENC_INDEX_EN)
//   pos   - signed position, CNT_W bits
//   x1/x2 - one-cycle pulse per counted CW / CCW step
//   dir   - direction of last counted step (1 = CW)
//   err   - sticky illegal-transition flag
//   ready - high once the post-reset settle window has elapsed
// ----------------------------------------------------------------------------
module quad_encoder_counter
   import qenc_pkg::*;
#(
   parameter int DEB_CNT  = 80,
   parameter int DEB_BITS = 7,
   parameter int CNT_W    = 16,
   parameter int MODE     = 0,
   parameter int WRAP     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d1,
   input  logic             d2,
   input  logic             en,
   input  logic             clr,
`ifdef QENC_INDEX_EN
   input  logic             idx,
`endif
   output logic [CNT_W-1:0] pos,
   output logic             x1,
   output logic             x2,
   output logic             dir,
   output logic             err,
   output logic             ready
);

   // Two spare bits so DEB_CNT+3 always fits even when DEB_CNT = 2^DEB_BITS-1.
   localparam int                  SETTLE_W    = DEB_BITS + 2;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(DEB_CNT + 3);
   localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
   localparam logic [CNT_W-1:0]    POS_MAX     = {1'b0, {(CNT_W-1){1'b1}}};
   localparam logic [CNT_W-1:0]    POS_MIN     = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0]    POS_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]    POS_ZERO    = CNT_W'(0);
   localparam logic                X1_MODE     = (MODE == MODE_X1);
   localparam logic                SATURATE    = (WRAP == 0);

   logic                a_s;
   logic                b_s;
   logic [1:0]          cur_s;
   logic [1:0]          prev_r;
   logic [SETTLE_W-1:0] settle_r;
   logic                ready_r;
   logic [CNT_W-1:0]    pos_r;
   logic                x1_r;
   logic                x2_r;
   logic                dir_r;
   logic                err_r;
   step_t               step_s;
   logic                idx_load_s;
   logic [CNT_W-1:0]    pos_inc_s;
   logic [CNT_W-1:0]    pos_dec_s;
   logic [CNT_W-1:0]    pos_nxt_s;
   logic                x1_nxt_s;
   logic                x2_nxt_s;
   logic                dir_nxt_s;
   logic                err_nxt_s;

   qenc_debounce #(.DEB_CNT(DEB_CNT), .DEB_BITS(DEB_BITS)) u_deb_a (
      .clk (clk), .rst (rst), .din (d1), .dout (a_s)
   );

   qenc_debounce #(.DEB_CNT(DEB_CNT), .DEB_BITS(DEB_BITS)) u_deb_b (
      .clk (clk), .rst (rst), .din (d2), .dout (b_s)
   );

   assign cur_s = {a_s, b_s};

`ifdef QENC_INDEX_EN
   logic idx_s;
   logic idx_prev_r;

   qenc_debounce #(.DEB_CNT(DEB_CNT), .DEB_BITS(DEB_BITS)) u_deb_idx (
      .clk (clk), .rst (rst), .din (idx), .dout (idx_s)
   );

   // Previous filtered index level for rising-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_prev_r <= 1'b0;
      end else begin
         idx_prev_r <= idx_s;
      end
   end

   assign idx_load_s = idx_s & ~idx_prev_r & ready_r & en;
`else
   assign idx_load_s = 1'b0;
`endif

   // Settle window: the filters start from 0, so decoding waits until they
   // have had time to follow the pins present at reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         settle_r <= SETTLE_W'(0);
         ready_r  <= 1'b0;
      end else if (!ready_r) begin
         if (settle_r == SETTLE_LAST) begin
            ready_r <= 1'b1;
         end else begin
            settle_r <= settle_r + SETTLE_ONE;
         end
      end
   end

   // Transition classification, suppressed until ready.
   always_comb begin
      if (ready_r) begin
         step_s = qenc_step(prev_r, cur_s, X1_MODE);
      end else begin
         step_s = STEP_NONE;
      end
   end

   assign pos_inc_s = (SATURATE && (pos_r == POS_MAX)) ? pos_r : pos_r + POS_ONE;
   assign pos_dec_s = (SATURATE && (pos_r == POS_MIN)) ? pos_r : pos_r - POS_ONE;

   // Next-state for the counter outputs. Priority: clr > idx > step.
   always_comb begin
      pos_nxt_s = pos_r;
      x1_nxt_s  = 1'b0;
      x2_nxt_s  = 1'b0;
      dir_nxt_s = dir_r;
      err_nxt_s = err_r;
      if (clr) begin
         pos_nxt_s = POS_ZERO;
         err_nxt_s = 1'b0;
      end else begin
         case (step_s)
            STEP_ILL: err_nxt_s = 1'b1;
            STEP_CW: begin
               if (en) begin
                  x1_nxt_s  = 1'b1;
                  dir_nxt_s = 1'b1;
                  pos_nxt_s = pos_inc_s;
               end else begin
                  pos_nxt_s = pos_r;
               end
            end
            STEP_CCW: begin
               if (en) begin
                  x2_nxt_s  = 1'b1;
                  dir_nxt_s = 1'b0;
                  pos_nxt_s = pos_dec_s;
               end else begin
                  pos_nxt_s = pos_r;
               end
            end
            default: pos_nxt_s = pos_r;
         endcase
         // An index load overrides the count but leaves the step pulse alone.
         if (idx_load_s) begin
            pos_nxt_s = POS_ZERO;
         end else begin
            err_nxt_s = err_nxt_s;
         end
      end
   end

   // Output and history registers; prev follows cur every cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_r <= S00;
         pos_r  <= POS_ZERO;
         x1_r   <= 1'b0;
         x2_r   <= 1'b0;
         dir_r  <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         prev_r <= cur_s;
         pos_r  <= pos_nxt_s;
         x1_r   <= x1_nxt_s;
         x2_r   <= x2_nxt_s;
         dir_r  <= dir_nxt_s;
         err_r  <= err_nxt_s;
      end
   end

   assign pos   = pos_r;
   assign x1    = x1_r;
   assign x2    = x2_r;
   assign dir   = dir_r;
   assign err   = err_r;
   assign ready = ready_r;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// ----------------------------------------------------------------------------
// tb_quad_encoder_counter
// Three counters (x4/wrap, x4/saturate, x1/wrap) share one set of pins. A
// move-level model (Gray index arithmetic, integer position) predicts pulses,
// pulse timing, pos, dir and err for each. Index checks under QENC_INDEX_EN.
// ----------------------------------------------------------------------------
module tb_quad_encoder_counter;

   localparam int DEB_CNT  = 4;
   localparam int DEB_BITS = 3;
   localparam int CNT_W    = 4;
   localparam int NI       = 3;
   localparam int LAT      = DEB_CNT + 3;   // pin change -> pulse, in cycles
   localparam int P_MAX    = (1 << (CNT_W - 1)) - 1;
   localparam int P_MIN    = -(1 << (CNT_W - 1));
   localparam int P_SPAN   = 1 << CNT_W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic d1  = 1'b1;
   logic d2  = 1'b1;
   logic en  = 1'b1;
   logic clr = 1'b0;
`ifdef QENC_INDEX_EN
   logic idx = 1'b0;
`endif

   logic [CNT_W-1:0] pos_w   [NI];
   logic             x1_w    [NI];
   logic             x2_w    [NI];
   logic             dir_w   [NI];
   logic             err_w   [NI];
   logic             ready_w [NI];

   always #50 clk = ~clk;

   quad_encoder_counter #(.DEB_CNT(DEB_CNT), .DEB_BITS(DEB_BITS), .CNT_W(CNT_W),
                          .MODE(0), .WRAP(1)) u_x4_wrap (
      .clk(clk), .rst(rst), .d1(d1), .d2(d2), .en(en), .clr(clr),
`ifdef QENC_INDEX_EN
      .idx(idx),
`endif
      .pos(pos_w[0]), .x1(x1_w[0]), .x2(x2_w[0]), .dir(dir_w[0]),
      .err(err_w[0]), .ready(ready_w[0]));

   quad_encoder_counter #(.DEB_CNT(DEB_CNT), .DEB_BITS(DEB_BITS), .CNT_W(CNT_W),
                          .MODE(0), .WRAP(0)) u_x4_sat (
      .clk(clk), .rst(rst), .d1(d1), .d2(d2), .en(en), .clr(clr),
`ifdef QENC_INDEX_EN
      .idx(idx),
`endif
      .pos(pos_w[1]), .x1(x1_w[1]), .x2(x2_w[1]), .dir(dir_w[1]),
      .err(err_w[1]), .ready(ready_w[1]));

   quad_encoder_counter #(.DEB_CNT(DEB_CNT), .DEB_BITS(DEB_BITS), .CNT_W(CNT_W),
                          .MODE(1), .WRAP(1)) u_x1_wrap (
      .clk(clk), .rst(rst), .d1(d1), .d2(d2), .en(en), .clr(clr),
`ifdef QENC_INDEX_EN
      .idx(idx),
`endif
      .pos(pos_w[2]), .x1(x1_w[2]), .x2(x2_w[2]), .dir(dir_w[2]),
      .err(err_w[2]), .ready(ready_w[2]));

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int         m_pos [NI];
   int         m_dir [NI];
   int         m_err [NI];
   logic [1:0] m_pins;
   int         exp_cw [NI];
   int         exp_ccw[NI];
   int         obs_cw [NI];
   int         obs_ccw[NI];
   int         first_t[NI];
   int         tot_cw [NI];
   int         tot_ccw[NI];

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   function automatic int inst_mode(input int i);
      return (i == 2) ? 1 : 0;
   endfunction

   function automatic int inst_wrap(input int i);
      return (i == 1) ? 0 : 1;
   endfunction

   // position of a pin state along the CW cycle 00,01,11,10
   function automatic int gray_idx(input logic [1:0] s);
      case (s)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [1:0] gray_state(input int k);
      case (k % 4)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   function automatic int model_add(input int i, input int p, input int d);
      int r;
      r = p + d;
      if (inst_wrap(i) == 1) begin
         if (r > P_MAX) r -= P_SPAN;
         else if (r < P_MIN) r += P_SPAN;
      end else begin
         if (r > P_MAX) r = P_MAX;
         else if (r < P_MIN) r = P_MIN;
      end
      return r;
   endfunction

   function automatic int pos_of(input int i);
      return int'($signed(pos_w[i]));
   endfunction

   task automatic clear_obs();
      for (int i = 0; i < NI; i++) begin
         obs_cw[i] = 0; obs_ccw[i] = 0; first_t[i] = 0;
         exp_cw[i] = 0; exp_ccw[i] = 0;
      end
   endtask

   // Advance n cycles (inputs driven just after each negedge), count pulses.
   task automatic run_ticks(input int n, input int clr_tick, input int base);
      for (int t = 1; t <= n; t++) begin
         clr = (t == clr_tick) ? 1'b1 : 1'b0;
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (x1_w[i]) begin
               obs_cw[i]++; tot_cw[i]++;
               if (first_t[i] == 0) first_t[i] = base + t;
            end
            if (x2_w[i]) begin
               obs_ccw[i]++; tot_ccw[i]++;
               if (first_t[i] == 0) first_t[i] = base + t;
            end
         end
      end
      clr = 1'b0;
   endtask

   task automatic check_obs(input string tag);
      for (int i = 0; i < NI; i++) begin
         check_val($sformatf("%s u%0d x1 pulses", tag, i), obs_cw[i], exp_cw[i]);
         check_val($sformatf("%s u%0d x2 pulses", tag, i), obs_ccw[i], exp_ccw[i]);
         if (exp_cw[i] + exp_ccw[i] > 0)
            check_val($sformatf("%s u%0d pulse cycle", tag, i), first_t[i], LAT);
         check_val($sformatf("%s u%0d pos", tag, i), pos_of(i), m_pos[i]);
         check_val($sformatf("%s u%0d dir", tag, i), int'(dir_w[i]), m_dir[i]);
         check_val($sformatf("%s u%0d err", tag, i), int'(err_w[i]), m_err[i]);
      end
   endtask

   // Model one settled pin change (clr_v = clear landing on the decode cycle).
   task automatic model_step(input logic [1:0] nxt, input logic en_v, input logic clr_v);
      int delta;
      delta = (gray_idx(nxt) - gray_idx(m_pins) + 4) % 4;
      for (int i = 0; i < NI; i++) begin
         if (clr_v) begin
            m_pos[i] = 0; m_err[i] = 0;
         end else if (delta == 2) begin
            m_err[i] = 1;
         end else if (delta != 0 && en_v && (inst_mode(i) == 0 || nxt == 2'b00)) begin
            if (delta == 1) begin
               exp_cw[i] = 1; m_dir[i] = 1; m_pos[i] = model_add(i, m_pos[i], 1);
            end else begin
               exp_ccw[i] = 1; m_dir[i] = 0; m_pos[i] = model_add(i, m_pos[i], -1);
            end
         end
      end
      m_pins = nxt;
   endtask

   task automatic move(input logic [1:0] nxt, input int hold, input logic en_v,
                       input int clr_tick, input string tag);
      clear_obs();
      model_step(nxt, en_v, clr_tick != 0);
      en = en_v; d1 = nxt[1]; d2 = nxt[0];
      run_ticks(hold, clr_tick, 0);
      check_obs(tag);
   endtask

   task automatic cw_n(input int n, input string tag);
      for (int k = 0; k < n; k++) move(gray_state(gray_idx(m_pins) + 1), 10, 1'b1, 0, tag);
   endtask

   task automatic ccw_n(input int n, input string tag);
      for (int k = 0; k < n; k++) move(gray_state(gray_idx(m_pins) + 3), 10, 1'b1, 0, tag);
   endtask

   task automatic glitch(input int g);
      clear_obs();
      en = 1'b1;
      d1 = ~m_pins[1];
      run_ticks(g, 0, 0);
      d1 = m_pins[1];
      run_ticks(12 - g, 0, g);
      check_obs("glitch");
   endtask

   task automatic do_reset(input logic [1:0] pins);
      #20 rst = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         check_val($sformatf("in reset u%0d pos", i), pos_of(i), 0);
         check_val($sformatf("in reset u%0d pulses", i), int'(x1_w[i]) + int'(x2_w[i]), 0);
         check_val($sformatf("in reset u%0d dir", i), int'(dir_w[i]), 0);
         check_val($sformatf("in reset u%0d err", i), int'(err_w[i]), 0);
         check_val($sformatf("in reset u%0d ready", i), int'(ready_w[i]), 0);
      end
      d1 = pins[1]; d2 = pins[0]; en = 1'b1; clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         m_pos[i] = 0; m_dir[i] = 0; m_err[i] = 0;
      end
      m_pins = pins;
      clear_obs();
      run_ticks(LAT, 0, 0);
      for (int i = 0; i < NI; i++)
         check_val($sformatf("ready low at cycle %0d u%0d", LAT, i), int'(ready_w[i]), 0);
      run_ticks(1, 0, LAT);
      for (int i = 0; i < NI; i++)
         check_val($sformatf("ready high at cycle %0d u%0d", LAT + 1, i), int'(ready_w[i]), 1);
      check_obs("settle");
   endtask

   task automatic rand_moves(input int n);
      int r, hold, ct;
      logic en_v;
      for (int k = 0; k < n; k++) begin
         r    = int'($urandom_range(0, 9));
         en_v = ($urandom_range(0, 4) != 0);
         hold = int'($urandom_range(LAT + 1, LAT + 6));
         if (r <= 3) begin
            ct = ($urandom_range(0, 7) == 0) ? LAT : 0;
            move(gray_state(gray_idx(m_pins) + 1), hold, en_v, ct, "rand cw");
         end else if (r <= 6) begin
            move(gray_state(gray_idx(m_pins) + 3), hold, en_v, 0, "rand ccw");
         end else if (r == 7) begin
            move(m_pins ^ 2'b11, hold, en_v, 0, "rand illegal");
         end else if (r == 8) begin
            move(m_pins, hold, en_v, int'($urandom_range(1, hold)), "rand clr");
         end else begin
            glitch(int'($urandom_range(1, DEB_CNT - 1)));
         end
      end
   endtask

`ifdef QENC_INDEX_EN
   task automatic idx_move(input logic lvl, input logic en_v, input string tag);
      int old_pos [NI];
      clear_obs();
      en = en_v; idx = lvl;
      for (int i = 0; i < NI; i++) begin
         old_pos[i] = m_pos[i];
         if (lvl && en_v) m_pos[i] = 0;
      end
      run_ticks(LAT - 1, 0, 0);
      for (int i = 0; i < NI; i++)
         check_val($sformatf("%s u%0d pos before load", tag, i), pos_of(i), old_pos[i]);
      run_ticks(4, 0, LAT - 1);
      check_obs(tag);
   endtask
`endif

   initial begin
      for (int i = 0; i < NI; i++) begin
         tot_cw[i] = 0; tot_ccw[i] = 0;
      end
      repeat (2) @(negedge clk);
      do_reset(2'b11);

      // x4 wrap / saturate: 12 CW edges then 1 CCW
      for (int i = 0; i < NI; i++) tot_cw[i] = 0;
      cw_n(12, "12 cw");
      check_val("x4 wrap pos after 12 cw", pos_of(0), -4);
      check_val("x4 wrap x1 total", tot_cw[0], 12);
      check_val("x4 sat pos after 12 cw", pos_of(1), 7);
      check_val("x4 wrap dir after cw", int'(dir_w[0]), 1);
      ccw_n(1, "1 ccw");
      check_val("x4 wrap pos after ccw", pos_of(0), -5);
      check_val("x4 wrap dir after ccw", int'(dir_w[0]), 0);

      // saturate: clear, 10 CW, 16 CCW
      move(m_pins, 10, 1'b1, 1, "clr");
      for (int i = 0; i < NI; i++) tot_cw[i] = 0;
      cw_n(10, "10 cw");
      check_val("sat clamps high", pos_of(1), 7);
      check_val("sat x1 total", tot_cw[1], 10);
      ccw_n(16, "16 ccw");
      check_val("sat clamps low", pos_of(1), -8);

      // x1 mode: one detent each way starting from 00
      cw_n(1, "to 00");
      move(m_pins, 10, 1'b1, 1, "clr");
      for (int i = 0; i < NI; i++) tot_cw[i] = 0;
      cw_n(4, "detent cw");
      check_val("x1 pos after cw detent", pos_of(2), 1);
      check_val("x1 pulses per detent", tot_cw[2], 1);
      ccw_n(4, "detent ccw");
      check_val("x1 pos after ccw detent", pos_of(2), 0);

      // glitch, illegal flip, clr against a legal step
      glitch(DEB_CNT - 1);
      move(m_pins ^ 2'b11, 10, 1'b1, 0, "illegal flip");
      check_val("illegal sets err", int'(err_w[0]), 1);
      move(gray_state(gray_idx(m_pins) + 1), 10, 1'b1, LAT, "clr with step");
      check_val("clr with step pos", pos_of(0), 0);
      check_val("clr with step err", int'(err_w[0]), 0);

      rand_moves(70);

      // reset while a change is still in the filters
      d1 = ~m_pins[1];
      run_ticks(3, 0, 0);
      do_reset({d1, d2});
      rand_moves(30);

`ifdef QENC_INDEX_EN
      move(m_pins, 10, 1'b1, 1, "idx prep clr");
      cw_n(5, "idx prep cw");
      check_val("idx prep pos", pos_of(0), 5);
      idx_move(1'b1, 1'b1, "idx rise en");
      check_val("idx load pos", pos_of(0), 0);
      idx_move(1'b0, 1'b1, "idx fall");
      cw_n(5, "idx prep cw2");
      idx_move(1'b1, 1'b0, "idx rise no en");
      check_val("idx ignored when disabled", pos_of(0), 5);
      idx_move(1'b0, 1'b1, "idx fall2");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
- Parametrised successor to the rotary-encoder front end: synchronises, debounces and quadrature-decodes one A/B encoder pair.
- Outputs per-step direction pulses and a signed position count, with selectable decoding mode and overflow policy.
- Sits between raw encoder pins and downstream user logic; runs on the 10 MHz system clock.

Parameters:
- DEB_CNT, 80, consecutive stable cycles required before a filtered input changes.
- DEB_BITS, 7, width of the debounce counter; must satisfy 2^DEB_BITS > DEB_CNT.
- CNT_W, 16, width of the signed position counter.
- MODE, 0, 0 = x4 decoding (every legal edge counts); 1 = x1 decoding (one count per detent).
- WRAP, 1, 1 = two's-complement wrap-around; 0 = saturate at the limits.

Ports:
- clk  in  1  system clock (10 MHz)
- rst  in  1  asynchronous, active-low reset
- d1  in  1  raw encoder channel A (asynchronous)
- d2  in  1  raw encoder channel B (asynchronous)
- en  in  1  count enable
- clr  in  1  synchronous clear of pos and err
- pos  out  CNT_W  signed position
- x1  out  1  one-cycle pulse on a counted CW step
- x2  out  1  one-cycle pulse on a counted CCW step
- dir  out  1  direction of last counted step: 1 = CW
- err  out  1  sticky illegal-transition flag
- ready  out  1  high once the post-reset settle window has elapsed

Behaviour:
- **Reset (rst=0):** all flops cleared asynchronously. Outputs: pos=0, x1=0, x2=0, dir=0, err=0, ready=0.
- **Synchronisation:** d1 and d2 each pass through a 2-FF synchroniser.
- **Debounce (per channel):**
  - Holds a stable value s.
  - While the synchronised input differs from s, the counter increments; while it equals s, the counter clears to 0.
  - When the counter reaches DEB_CNT-1 with the input still differing, s toggles and the counter clears.
  - Pin-to-s latency: 2 + DEB_CNT cycles.
- **Settle window:**
  - For the first DEB_CNT+3 cycles after reset release, the prev register {a,b} loads {sA,sB} every cycle.
  - No counting, no pulses and no err during this window.
  - ready rises on the following cycle and stays high until the next reset.
- **Decode (when ready):** compare prev against cur={sA,sB}; prev<=cur every cycle, regardless of en.
  - CW sequence: 00->01->11->10->00. CCW is the reverse.
  - cur==prev: no event.
  - Both bits change: illegal. err<=1 (sticky), no count, no pulse.
  - MODE=0: every legal CW edge is a +1 step; every legal CCW edge is a -1 step.
  - MODE=1: only 10->00 is a +1 step and only 01->00 is a -1 step. Other legal edges are silent.
- **Step effects (en=1):**
  - x1 or x2 pulses for exactly 1 cycle, registered, one cycle after cur changes.
  - pos updates on the same cycle as the pulse.
  - dir <= 1 on a CW step, 0 on a CCW step.
- **en=0:** debounce and prev tracking keep running; pos, dir and pulses hold, with pulses at 0. err still latches.
- **Arithmetic:**
  - WRAP=1: max+1 -> min and min-1 -> max.
  - WRAP=0: pos clamps at 2^(CNT_W-1)-1 / -2^(CNT_W-1). The pulse and dir still update while clamped.
- **clr:** same-cycle priority clr > step. pos<=0 and err<=0; any step in that cycle is dropped (no pulse). dir is unchanged.
- **Reset mid-rotation:** everything returns to reset values; the settle window restarts, so no spurious step or err from the pin state present at release.

Optional Feature:
- **Macro:** QENC_INDEX_EN.
- **When defined:**
  - Adds input port idx (1 bit), synchronised and debounced identically to d1/d2.
  - A rising edge of filtered idx while ready=1 and en=1 loads pos<=0.
  - Priority: clr > idx > step. A step coincident with an idx edge is dropped, but its pulse still fires.
- **When undefined:** no idx port and no index logic.

Decomposition:
- **Package qenc_pkg:**
  - state localparams S00, S01, S11, S10;
  - MODE_X4 = 0 and MODE_X1 = 1;
  - a function returning step (+1 / -1 / 0 / illegal) from {prev, cur}.
- **Sub-module qenc_debounce:** synchroniser + debounce filter, parameters DEB_CNT and DEB_BITS, ports clk, rst, din, dout. Instantiated two times (three with QENC_INDEX_EN).

Test Plan (bench overrides DEB_CNT=4, DEB_BITS=3, CNT_W=4 unless noted):
- Reset, then hold d1=1, d2=1 through release -> ready rises at cycle 8; err=0, pos=0, no pulses.
- MODE=0: drive 3 full CW cycles (12 edges, each held ≥10 clk) -> 12 x1 pulses, pos=-4 (wrap from 7 at the 8th step), dir=1; then 1 CCW edge -> x2 pulse, pos=-5, dir=0.
- WRAP=0: 10 CW edges from 0 -> pos clamps at 7, x1 pulses=10; then 16 CCW edges -> pos clamps at -8.
- MODE=1: one full CW detent (4 edges) -> exactly one x1 pulse on 10->00, pos=1; one CCW detent -> pos=0.
- Glitch of 3 cycles on d1, plus a simultaneous A/B flip held for 10 cycles -> glitch is ignored; flip sets err=1 and pos is unchanged. Asserting clr in the same cycle as a legal step -> pos=0, err=0, no pulse.
- QENC_INDEX_EN defined: pos=5, idx rising edge -> pos=0 one cycle after filtered idx rises; with en=0 -> pos stays 5.
